// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, byte address to word index, optional
// wait states, registered response with misalignment/range error flagging.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH       = 2048,
  parameter int unsigned IDX_W       = 11,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] err_count
);

  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [IDX_W-1:0]  idx_q;
  logic              err_q;
  logic [3:0]        cnt_q;

  logic [31:0]       mem [DEPTH];

  logic [29:0]       off_word_c;
  logic              req_err_c;
  logic              accept_c;
  logic              commit_c;
  logic              cur_we_c;
  logic [31:0]       cur_wdata_c;
  logic [IDX_W-1:0]  cur_idx_c;
  logic              cur_err_c;

  // Base is word aligned, so the word offset is exactly the byte offset shifted by two.
  always_comb begin
    off_word_c = req_addr[31:2] - BASE_WORD;
    req_err_c  = (req_addr[1:0] != 2'b00) | (req_addr < BASE_ADDR) |
                 (off_word_c >= 30'(DEPTH));
    accept_c   = (state_q == S_IDLE) & req_valid & req_ready;
    commit_c   = (accept_c & (WAIT_CYCLES == 0)) |
                 ((state_q == S_WAIT) & (cnt_q <= 4'd1));
    // With no wait states the commit edge is the accept edge, so use live inputs.
    if (state_q == S_IDLE) begin
      cur_we_c    = req_we;
      cur_wdata_c = req_wdata;
      cur_idx_c   = off_word_c[IDX_W-1:0];
      cur_err_c   = req_err_c;
    end else begin
      cur_we_c    = we_q;
      cur_wdata_c = wdata_q;
      cur_idx_c   = idx_q;
      cur_err_c   = err_q;
    end
  end

  // Storage is never reset; writes only on a clean commit edge.
  always_ff @(posedge clk) begin
    if (commit_c && cur_we_c && !cur_err_c) begin
      mem[cur_idx_c] <= cur_wdata_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (accept_c) begin
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            idx_q     <= off_word_c[IDX_W-1:0];
            err_q     <= req_err_c;
            cnt_q     <= WAIT_LD;
            req_ready <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase

      // Commit overrides the per-state updates above on the edge entering RESP.
      if (commit_c) begin
        state_q   <= S_RESP;
        cnt_q     <= '0;
        rsp_valid <= 1'b1;
        rsp_err   <= cur_err_c;
        rsp_rdata <= (!cur_we_c && !cur_err_c) ? mem[cur_idx_c] : 32'h0;
        if (cur_err_c && (err_count != 16'hFFFF)) begin
          err_count <= err_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with a single wait state, one with none.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        rr1, rv1, re1;
  logic [31:0] rd1;
  logic [15:0] ec1;
  logic        rr0, rv0, re0;
  logic [31:0] rd0;
  logic [15:0] ec0;

  logic        rr, rv, re;
  logic [31:0] rd;

  int checks;
  int failures;

  dmem_responder #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(rr1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1),
    .rsp_err(re1), .err_count(ec1)
  );

  dmem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(rr0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0),
    .rsp_err(re0), .err_count(ec0)
  );

  assign rr = sel ? rr0 : rr1;
  assign rv = sel ? rv0 : rv1;
  assign re = sel ? re0 : re1;
  assign rd = sel ? rd0 : rd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full request/response; hold>0 keeps rsp_ready low and offers a competing request.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd,
                     input logic exp_err, input int lat, input int hold);
    int n;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (rr !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = addr ^ 32'h0000_0008;
    req_wdata = ~wdata;
    n = 1;
    while (rv !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(re), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = BASE + 32'h8;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(rv), 32'd1);
      chk({tag, "_hold_rdata"}, rd, exp_rd);
      chk({tag, "_hold_ready"}, 32'(rr), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(rv), 32'd0);
    chk({tag, "_post_ready"}, 32'(rr), 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    sel       = 1'b0;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    #1;
    chk("rst_req_ready", 32'(rr1), 32'd0);
    chk("rst_rsp_valid", 32'(rv1), 32'd0);
    chk("rst_rsp_rdata", rd1, 32'h0);
    chk("rst_err_count", 32'(ec1), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", 32'(rr1), 32'd1);

    // Write then read back with one wait state.
    txn("t1_wr", 1'b1, BASE + 32'h4, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0);
    txn("t1_rd", 1'b0, BASE + 32'h4, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);

    // Misaligned read flags an error and leaves storage alone.
    txn("t2_mis", 1'b0, BASE + 32'h2, 32'h0, 32'h0, 1'b1, 2, 0);
    chk("t2_err_count", 32'(ec1), 32'd1);
    txn("t2_rd", 1'b0, BASE + 32'h4, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);

    // Out-of-range writes on both sides of the segment.
    txn("t3_w0", 1'b1, BASE, 32'h1111_0000, 32'h0, 1'b0, 2, 0);
    txn("t3_wlast", 1'b1, BASE + 32'h1FFC, 32'h2222_FFFF, 32'h0, 1'b0, 2, 0);
    txn("t3_below", 1'b1, 32'h1000_FFFC, 32'hBAD0_BAD0, 32'h0, 1'b1, 2, 0);
    txn("t3_above", 1'b1, BASE + 32'h2000, 32'hBAD1_BAD1, 32'h0, 1'b1, 2, 0);
    chk("t3_err_count", 32'(ec1), 32'd3);
    txn("t3_r0", 1'b0, BASE, 32'h0, 32'h1111_0000, 1'b0, 2, 0);
    txn("t3_rlast", 1'b0, BASE + 32'h1FFC, 32'h0, 32'h2222_FFFF, 1'b0, 2, 0);

    // Backpressure on the response.
    txn("t4_hold", 1'b0, BASE + 32'h4, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 5);
    txn("t4_after", 1'b0, BASE + 32'h8, 32'h0, 32'h0, 1'b0, 2, 0);

    // Zero wait states, end words of the segment.
    sel = 1'b1;
    txn("t5_w0", 1'b1, BASE, 32'hA0A0_A0A0, 32'h0, 1'b0, 1, 0);
    txn("t5_wlast", 1'b1, BASE + 32'h1FFC, 32'hB1B1_B1B1, 32'h0, 1'b0, 1, 0);
    txn("t5_r0", 1'b0, BASE, 32'h0, 32'hA0A0_A0A0, 1'b0, 1, 0);
    txn("t5_rlast", 1'b0, BASE + 32'h1FFC, 32'h0, 32'hB1B1_B1B1, 1'b0, 1, 0);
    chk("t5_err_count", 32'(ec0), 32'd0);

    // Reset during the wait state of a write drops it.
    sel = 1'b0;
    txn("t6_old", 1'b1, BASE + 32'h10, 32'h0BAD_F00D, 32'h0, 1'b0, 2, 0);
    req_we    = 1'b1;
    req_addr  = BASE + 32'h10;
    req_wdata = 32'h1234_5678;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t6_in_wait", 32'(rv1), 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(rv1), 32'd0);
    chk("t6_rst_ready", 32'(rr1), 32'd0);
    chk("t6_rst_errcnt", 32'(ec1), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    txn("t6_rd", 1'b0, BASE + 32'h10, 32'h0, 32'h0BAD_F00D, 1'b0, 2, 0);
    txn("t6_keep", 1'b0, BASE + 32'h4, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
